// File: rtl/ulbf_data_pkg.sv
// rtl/ulbf_data_pkg.sv - shared types and constants for the ULBF data capture path
package ulbf_data_pkg;

    localparam int GO_SYNC_STAGES   = 3;
    localparam int DONE_PIPE_STAGES = 4;
    localparam int CNT_W            = 12;
    localparam int ADDR_W           = 16;
    localparam int ERR_CNT_W        = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } cap_state_e;

    // Next write address with wrap back to 0 after the last address.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] addr,
                                                   input logic [ADDR_W-1:0] last);
        return (addr == last) ? '0 : addr + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/ulbf_data_axis2ram_64b_if.sv
// rtl/ulbf_data_axis2ram_64b_if.sv - stream bundle feeding the capture block
interface ulbf_data_axis2ram_64b_if #(
    parameter int DATA_WIDTH = 64
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/ulbf_data_xpm_ram.sv
// rtl/ulbf_data_xpm_ram.sv - byte-writable dual-port RAM, port A pipelined read
module ulbf_data_xpm_ram #(
    parameter int    DATA_WIDTH       = 64,
    parameter int    RAM_DEPTH        = 4096,
    parameter int    RAM_READ_LATENCY = 4,
    parameter int    ADDR_WIDTH       = 16,
    parameter string MEM_INIT_FILE    = "none"
) (
    input  logic                    bram_clk,
    input  logic                    m_axis_clk,
    input  logic                    ena,
    input  logic [DATA_WIDTH/8-1:0] wea,
    input  logic [ADDR_WIDTH-1:0]   addra,
    input  logic [DATA_WIDTH-1:0]   dina,
    output logic [DATA_WIDTH-1:0]   douta,
    input  logic                    enb,
    input  logic [DATA_WIDTH/8-1:0] web,
    input  logic [ADDR_WIDTH-1:0]   addrb,
    input  logic [DATA_WIDTH-1:0]   dinb,
    output logic [DATA_WIDTH-1:0]   doutb
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int AW = $clog2(RAM_DEPTH);
    // Preload comes from the vendor memory flow; this model starts undefined.
    localparam bit unused_mem_init = (MEM_INIT_FILE != "none");

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] douta_pipe [RAM_READ_LATENCY];
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^{addra, addrb};

    // Common-clock RAM: both write ports land on bram_clk; when both hit the
    // same word in one cycle the content is undefined by contract.
    always_ff @(posedge bram_clk) begin
        if (enb) begin
            for (int i = 0; i < NB; i++) begin
                if (web[i]) mem[addrb[AW-1:0]][i*8 +: 8] <= dinb[i*8 +: 8];
            end
        end
        if (ena) begin
            for (int i = 0; i < NB; i++) begin
                if (wea[i]) mem[addra[AW-1:0]][i*8 +: 8] <= dina[i*8 +: 8];
            end
            douta_pipe[0] <= mem[addra[AW-1:0]];
        end
        for (int i = 1; i < RAM_READ_LATENCY; i++) begin
            douta_pipe[i] <= douta_pipe[i-1];
        end
    end

    assign douta = douta_pipe[RAM_READ_LATENCY-1];

    always_ff @(posedge m_axis_clk) begin
        if (enb) doutb <= mem[addrb[AW-1:0]];
    end

endmodule

// File: rtl/ulbf_data_axis2ram_64b.sv
// rtl/ulbf_data_axis2ram_64b.sv - AXIS capture into RAM with framing check (opt. ULBF_AXIS2RAM_TKEEP_EN)
module ulbf_data_axis2ram_64b
    import ulbf_data_pkg::*;
#(
    parameter int    DATA_WIDTH       = 64,
    parameter int    RAM_DEPTH        = 4096,
    parameter int    RAM_READ_LATENCY = 4,
    parameter string MEM_INIT_FILE    = "none"
) (
    input  logic                    s_axis_clk,
    input  logic                    s_axis_rst,
    input  logic                    go,
    output logic                    done,
    output logic                    tlast_err,
    output logic [ERR_CNT_W-1:0]    err_count,
    output logic [ADDR_W-1:0]       addrb_wire,
    input  logic [CNT_W-1:0]        block_size,
    input  logic [CNT_W-1:0]        niter,
    input  logic [ADDR_W-1:0]       rollover_addr,
    ulbf_data_axis2ram_64b_if.slave s_axis,
    input  logic                    ena,
    input  logic [DATA_WIDTH/8-1:0] wea,
    input  logic [ADDR_W-1:0]       addra,
    input  logic [DATA_WIDTH-1:0]   dina,
    output logic [DATA_WIDTH-1:0]   douta
);
    localparam int KEEP_W = DATA_WIDTH / 8;

    logic [GO_SYNC_STAGES-1:0]   go_sync;
    logic                        go_int;
    cap_state_e                  state;
    logic                        tready_r;
    logic [CNT_W-1:0]            block_counter;
    logic [CNT_W-1:0]            iter_counter;
    logic [CNT_W-1:0]            bs_m1;
    logic [CNT_W-1:0]            niter_m1;
    logic [CNT_W-1:0]            niter_l;
    logic [ADDR_W-1:0]           roll_m1;
    logic [ADDR_W-1:0]           addrb;
    logic                        wr_en;
    logic                        wr_final;
    logic [ADDR_W-1:0]           wr_addr;
    logic [DATA_WIDTH-1:0]       wr_data;
    logic [KEEP_W-1:0]           wr_keep;
    logic [KEEP_W-1:0]           beat_keep;
    logic                        done_int;
    logic [DONE_PIPE_STAGES-1:0] done_pipe;
    logic                        beat;
    logic                        block_end;
    logic                        final_beat;
    logic [DATA_WIDTH-1:0]       unused_doutb;

`ifdef ULBF_AXIS2RAM_TKEEP_EN
    assign beat_keep = s_axis.tkeep;
`else
    logic unused_tkeep;
    assign beat_keep    = '1;
    assign unused_tkeep = ^s_axis.tkeep;
`endif

    always_ff @(posedge s_axis_clk) begin
        if (s_axis_rst) go_sync <= '0;
        else            go_sync <= {go_sync[GO_SYNC_STAGES-2:0], go};
    end

    assign go_int     = go_sync[GO_SYNC_STAGES-1];
    assign beat       = s_axis.tvalid & tready_r;
    assign block_end  = (block_counter == bs_m1);
    assign final_beat = (niter_l != '0) && (iter_counter == niter_m1) && block_end;

    always_ff @(posedge s_axis_clk) begin
        if (s_axis_rst) begin
            state         <= IDLE;
            tready_r      <= 1'b0;
            block_counter <= '0;
            iter_counter  <= '0;
            bs_m1         <= '0;
            niter_m1      <= '0;
            niter_l       <= '0;
            roll_m1       <= '0;
            addrb         <= '0;
            wr_en         <= 1'b0;
            wr_final      <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            wr_keep       <= '0;
            done_int      <= 1'b0;
            done_pipe     <= '0;
            tlast_err     <= 1'b0;
            err_count     <= '0;
        end else begin
            wr_en     <= beat;
            wr_final  <= beat & final_beat;
            done_pipe <= {done_pipe[DONE_PIPE_STAGES-2:0], done_int};
            if (beat) begin
                wr_addr <= addrb;
                wr_data <= s_axis.tdata;
                wr_keep <= beat_keep;
            end
            // done_int follows the RAM write of the last beat, not its acceptance.
            if (wr_final) done_int <= 1'b1;

            case (state)
                IDLE: begin
                    tready_r      <= 1'b0;
                    block_counter <= '0;
                    iter_counter  <= '0;
                    addrb         <= '0;
                    done_int      <= 1'b0;
                    if (go_int) begin
                        bs_m1    <= block_size - CNT_W'(1);
                        niter_m1 <= niter - CNT_W'(1);
                        roll_m1  <= rollover_addr - ADDR_W'(1);
                        niter_l  <= niter;
                        state    <= CAPTURE;
                        tready_r <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (beat) begin
                        addrb <= wrap_inc(addrb, roll_m1);
                        // Block position is counted, never re-aligned from tlast.
                        if (block_end) begin
                            block_counter <= '0;
                            iter_counter  <= iter_counter + CNT_W'(1);
                        end else begin
                            block_counter <= block_counter + CNT_W'(1);
                        end
                        if (s_axis.tlast != block_end) begin
                            tlast_err <= 1'b1;
                            if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
                        end
                        if (final_beat) begin
                            state    <= DONE;
                            tready_r <= 1'b0;
                        end
                    end
                    if (!go_int) begin
                        state    <= IDLE;
                        tready_r <= 1'b0;
                        done_int <= 1'b0;
                    end
                end
                DONE: begin
                    if (!go_int) begin
                        state    <= IDLE;
                        done_int <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tready_r <= 1'b0;
                end
            endcase
        end
    end

    assign s_axis.tready = tready_r;
    assign done          = done_pipe[DONE_PIPE_STAGES-1];
    assign addrb_wire    = addrb;

    ulbf_data_xpm_ram #(
        .DATA_WIDTH       (DATA_WIDTH),
        .RAM_DEPTH        (RAM_DEPTH),
        .RAM_READ_LATENCY (RAM_READ_LATENCY),
        .ADDR_WIDTH       (ADDR_W),
        .MEM_INIT_FILE    (MEM_INIT_FILE)
    ) u_ram (
        .bram_clk   (s_axis_clk),
        .m_axis_clk (s_axis_clk),
        .ena        (ena),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina),
        .douta      (douta),
        .enb        (1'b1),
        .web        (wr_en ? wr_keep : '0),
        .addrb      (wr_addr),
        .dinb       (wr_data),
        .doutb      (unused_doutb)
    );

endmodule
